// File: rtl/regfile_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_if
//
// Purpose: bundles the two requester write ports, the control-unit hold and the
// register-bank write-stage outputs of regfile_write_arbiter.
//
// Signals:
//   req0/req1     requester write request (0 = ALU writeback, 1 = load unit)
//   addr0/addr1   target register index
//   data0/data1   write data
//   gnt0/gnt1     grant; a transfer happens on an edge where req & gnt
//   hold          control-unit stall, blocks new grants
//   chosen        one-hot register select of the write stage
//   w_en          bank write enable
//   w_data        bank write data
//   busy          mirrors w_en
//   err           sticky protocol error
//
// Modports:
//   master  requester / control side (drives requests and hold)
//   slave   arbiter side
// -----------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int DW   = 9
);
    logic            req0;
    logic            req1;
    logic [AW-1:0]   addr0;
    logic [AW-1:0]   addr1;
    logic [DW-1:0]   data0;
    logic [DW-1:0]   data1;
    logic            gnt0;
    logic            gnt1;
    logic            hold;
    logic [NREG-1:0] chosen;
    logic            w_en;
    logic [DW-1:0]   w_data;
    logic            busy;
    logic            err;

    modport master (
        output req0, req1, addr0, addr1, data0, data1, hold,
        input  gnt0, gnt1, chosen, w_en, w_data, busy, err
    );

    modport slave (
        input  req0, req1, addr0, addr1, data0, data1, hold,
        output gnt0, gnt1, chosen, w_en, w_data, busy, err
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose: round-robin arbiter for two register-bank writers. Grants are
// combinational; the winning write is captured into a single registered write
// stage that drives the bank's one-hot select, write enable and write data.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-low reset
//   bus   regfile_write_arbiter_if.slave (requests, grants, hold, write stage,
//         busy, err)
//
// Optional feature: define REGFILE_ARB_ERR_CHECK_EN to build the protocol
// checker that drives the sticky err output. Without it err is tied to 0.
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int NREG = 8,
    parameter int AW   = 3,
    parameter int DW   = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_arbiter_if.slave  bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_ptr;
    logic [NREG-1:0] r_chosen;
    logic [DW-1:0]   r_wdata;

    logic            w_gnt0;
    logic            w_gnt1;
    logic            w_xfer;
    logic            w_win;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data_win;
    logic            w_addr_ok;
    logic            w_load;

    // A requester wins when it is alone or when the pointer favours it.
    // Reset and hold suppress both grants.
    assign w_gnt0     = rst & ~bus.hold & bus.req0 & (~bus.req1 | ~r_ptr);
    assign w_gnt1     = rst & ~bus.hold & bus.req1 & (~bus.req0 |  r_ptr);
    assign w_xfer     = w_gnt0 | w_gnt1;
    assign w_win      = w_gnt1;
    assign w_addr     = w_win ? bus.addr1 : bus.addr0;
    assign w_data_win = w_win ? bus.data1 : bus.data0;
    assign w_addr_ok  = (32'(w_addr) < NREG);
    // Out-of-range addresses still complete the handshake, but the write is
    // dropped so the stage stays idle.
    assign w_load     = w_xfer & w_addr_ok;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE:  w_state_nxt = w_load ? ST_WRITE : ST_IDLE;
            ST_WRITE: w_state_nxt = w_load ? ST_WRITE : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr    <= 1'b0;
            r_chosen <= '0;
            r_wdata  <= '0;
        end else begin
            // The pointer moves to whichever requester did not win.
            if (w_xfer) begin
                r_ptr   <= ~w_win;
                r_wdata <= w_data_win;
            end
            r_chosen <= w_load ? (NREG'(1) << w_addr) : '0;
        end
    end

    assign bus.gnt0   = w_gnt0;
    assign bus.gnt1   = w_gnt1;
    assign bus.chosen = r_chosen;
    assign bus.w_en   = (r_state == ST_WRITE);
    assign bus.busy   = (r_state == ST_WRITE);
    assign bus.w_data = r_wdata;

`ifdef REGFILE_ARB_ERR_CHECK_EN
    // A request is pending when it was raised but not granted on the last
    // edge; a pending request must keep req, addr and data unchanged.
    logic          r_pend0;
    logic          r_pend1;
    logic [AW-1:0] r_paddr0;
    logic [AW-1:0] r_paddr1;
    logic [DW-1:0] r_pdata0;
    logic [DW-1:0] r_pdata1;
    logic          r_err;
    logic          w_viol;

    assign w_viol = (r_pend0 & (~bus.req0 | (bus.addr0 != r_paddr0) | (bus.data0 != r_pdata0)))
                  | (r_pend1 & (~bus.req1 | (bus.addr1 != r_paddr1) | (bus.data1 != r_pdata1)))
                  | (w_xfer & ~w_addr_ok);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pend0  <= 1'b0;
            r_pend1  <= 1'b0;
            r_paddr0 <= '0;
            r_paddr1 <= '0;
            r_pdata0 <= '0;
            r_pdata1 <= '0;
            r_err    <= 1'b0;
        end else begin
            r_pend0  <= bus.req0 & ~w_gnt0;
            r_pend1  <= bus.req1 & ~w_gnt1;
            r_paddr0 <= bus.addr0;
            r_paddr1 <= bus.addr1;
            r_pdata0 <= bus.data0;
            r_pdata1 <= bus.data1;
            r_err    <= r_err | w_viol;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Round-robin write-port arbiter and sequencer for the CPU's bank of 9-bit registers. Two requesters, 0 = ALU writeback and 1 = load unit, present register writes through a req/gnt handshake. The block serialises them, including same-cycle collisions, into a single registered write stage. That stage drives the bank's per-register `chosen`, shared `w_en` and shared `w_data` lines, and supports a control-unit `hold` and optional protocol-error detection.

## Interface
Parameters:
- `NREG`, 8: number of registers in the bank (2..2^AW).
- `AW`, 3: register address width.
- `DW`, 9: data width; must match register width.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous, active-low. Sampled only on the rising edge of `clk`.
- `req0` / `req1` input 1: write request from requester 0 / 1.
- `addr0` / `addr1` input AW: target register index.
- `data0` / `data1` input DW: write data.
- `gnt0` / `gnt1` output 1: grant; a transfer occurs on an edge where `req_i & gnt_i`.
- `hold` input 1: control-unit stall; blocks new grants.
- `chosen` output NREG: one-hot register select for the registered write stage.
- `w_en` output 1: write enable to the bank.
- `w_data` output DW: write data to the bank.
- `busy` output 1: equals `w_en`.
- `err` output 1: sticky protocol error (see Configuration).

## Operation
Grant logic:
- Grants are combinational from `req0`, `req1`, `hold`, `rst` and the priority pointer `ptr`.
- At most one grant is asserted per cycle.
- No grant is asserted while `hold=1` or `rst=0`.
- With a single requester active, that requester is granted.
- With both active, the requester equal to `ptr` wins.
- After each transfer, `ptr` becomes the index of the non-winning requester.
- `ptr` is unchanged in cycles with no transfer.

Write stage:
- On a transfer edge, the stage loads `chosen = 1 << addr`, `w_en = 1` and `w_data = data` of the winner.
- With no transfer, the stage loads `chosen = 0` and `w_en = 0`; `w_data` holds its last value.
- If `addr >= NREG`, the transfer still completes with `chosen = 0` and `w_en = 0`, i.e. the write is dropped.
- The bank commits when `chosen[k] & w_en` at the edge after the stage loads.

Collision rules:
- Both requesters targeting the same register in the same cycle: the winner is written first and the loser one transfer later. The loser's data is therefore final (last grant wins).
- The loser must keep `req`, `addr` and `data` stable until granted.

Two-state FSM, tracking whether the write stage is loaded:
- IDLE: `w_en = 0`.
- WRITE: `w_en = 1`.
- Transitions:
  - IDLE→WRITE on a transfer.
  - WRITE→WRITE on a transfer, giving back-to-back writes every cycle.
  - WRITE→IDLE on no transfer.
  - Any state→IDLE on `rst = 0`.

## Timing
- Request-to-grant latency is 0 cycles; grant is in the same cycle as the request if it wins.
- Transfer-to-bank latency: `w_en`/`chosen` are valid 1 cycle after the transfer edge, and the bank updates on the following edge.
- Throughput is 1 write per cycle with continuous requests; two contending requesters alternate 0,1,0,1….
- `hold` asserted: no grant in that cycle, and `w_en = 0` on the next cycle. A write already in the stage completes normally.
- Reset values, on the edge with `rst = 0`:
  - `chosen = 0`, `w_en = 0`, `w_data = 0`, `busy = 0`, `err = 0`.
  - `ptr = 0` (requester 0 favoured).
  - `gnt0` and `gnt1` are 0 throughout reset.
- Reset mid-operation: a write in the stage at the reset edge is discarded, and any pending request must re-request after reset.

## Configuration
- `REGFILE_ARB_ERR_CHECK_EN` defined: `err` is set, and held until reset, on any of:
  - a requester dropping `req` without being granted;
  - a requester changing `addr` or `data` while `req = 1` and `gnt = 0`;
  - a transfer with `addr >= NREG`.
- `err` rises 1 cycle after the offending edge.
- Not defined: the checker logic is absent and `err` is tied to 0.

## Test plan
- Reset with `rst = 0` for 2 cycles while `req0 = 1` -> `gnt0 = 0`, `w_en = 0`, `chosen = 0`, `err = 0`. After release, `gnt0 = 1` in the first cycle.
- `req0 = 1`, `addr0 = 3`, `data0 = 9'h1A5` alone -> `gnt0 = 1`. Next cycle `chosen = 8'b0000_1000`, `w_en = 1`, `w_data = 9'h1A5`. Register 3 reads `9'h1A5` one cycle later.
- Both requesting from reset (`addr0 = 2`, `data0 = 9'h011`; `addr1 = 2`, `data1 = 9'h122`) -> requester 0 granted first, requester 1 the next cycle. Register 2 ends at `9'h122`; `ptr` ends at 0.
- Continuous contention for 6 cycles -> grants alternate 0,1,0,1,0,1 and `w_en` stays 1 on every cycle.
- `hold = 1` for 3 cycles with `req1 = 1` -> no `gnt1`, `w_en = 0` from the second cycle. After `hold` drops, `gnt1 = 1` the same cycle.
- With the macro defined, `req0` dropped before grant while `req1` is winning -> `err = 1` one cycle later and stays 1 until `rst = 0`. Without the macro, `err = 0`.
